regfile_scoreboard: RTL and testbench

- Integer register file for the pipeline. It sits at the receiving end of the write-back stage's write_data / write_reg / write_enable interface.
- Provides two combinational read ports with write-through bypass for decode.
- Holds a per-register busy scoreboard: set on issue, cleared on write-back. Decode gets a stall signal for RAW/WAW hazards and a pending-write count.

---
 rtl/regfile_scoreboard.sv | 137 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register busy scoreboard.
// - Two combinational read ports, with same-cycle bypass from write-back.
// - A busy bit is set when an instruction that writes a register issues and
//   cleared when that register is written back; flush clears every busy bit.
// - The stall output flags RAW and WAW hazards; pending_count is a registered
//   count of busy registers.
// Optional feature: define SCOREBOARD_CHECK_EN to add the sticky
// wb_unexpected output, which flags a write-back to a register that is not
// busy, unless a flush happened in the previous cycle.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_enable,
  input  logic [ADDR_WIDTH-1:0] wb_reg,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  issue_valid,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  issue_writes,
  input  logic [ADDR_WIDTH-1:0] issue_dest,
  input  logic                  flush,
  output logic                  stall,
  output logic                  issue_accept,
  output logic [ADDR_WIDTH:0]   pending_count
`ifdef SCOREBOARD_CHECK_EN
  ,
  output logic                  wb_unexpected
`endif
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_eff;
  logic [NUM_REGS-1:0]   busy_next;
  logic [ADDR_WIDTH:0]   busy_next_cnt;
  logic                  wb_write;

  // x0 is never a write target.
  assign wb_write = wb_enable && (wb_reg != '0);

  // Register storage; x0 is never written, so it stays zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_write) begin
      regs[wb_reg] <= wb_data;
    end
  end

  // Read ports: x0 reads zero, and a write-back to the same register is bypassed.
  always_comb begin
    rs1_data = regs[rs1_addr];
    if (rs1_addr == '0)
      rs1_data = '0;
    else if (wb_enable && (wb_reg == rs1_addr))
      rs1_data = wb_data;

    rs2_data = regs[rs2_addr];
    if (rs2_addr == '0)
      rs2_data = '0;
    else if (wb_enable && (wb_reg == rs2_addr))
      rs2_data = wb_data;
  end

  // A write-back arriving this cycle resolves the hazard right away.
  always_comb begin
    busy_eff = '0;
    for (int r = 0; r < NUM_REGS; r++)
      busy_eff[r] = busy[r] && !(wb_enable && (wb_reg == ADDR_WIDTH'(r)));
  end

  // Hazard detection and issue acceptance.
  always_comb begin
    stall = issue_valid && !flush &&
            ((rs1_used     && busy_eff[rs1_addr]) ||
             (rs2_used     && busy_eff[rs2_addr]) ||
             (issue_writes && busy_eff[issue_dest]));
    issue_accept = issue_valid && !stall && !flush;
  end

  // Next busy vector. If an issue and a write-back hit the same register on
  // the same edge, the issue's set wins. Flush clears every busy bit.
  always_comb begin
    busy_next = busy;
    if (wb_write)
      busy_next[wb_reg] = 1'b0;
    if (issue_accept && issue_writes && (issue_dest != '0))
      busy_next[issue_dest] = 1'b1;
    if (flush)
      busy_next = '0;
    busy_next[0] = 1'b0;
  end

  // Count the busy bits in the next busy vector.
  always_comb begin
    busy_next_cnt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      busy_next_cnt = busy_next_cnt + {{ADDR_WIDTH{1'b0}}, busy_next[i]};
  end

  // Register the busy vector and its count together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy          <= '0;
      pending_count <= '0;
    end else begin
      busy          <= busy_next;
      pending_count <= busy_next_cnt;
    end
  end

`ifdef SCOREBOARD_CHECK_EN
  logic flush_q;

  // Sticky flag for a write-back to a non-busy register. A write-back in the
  // cycle after a flush is expected, so it is not flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_q       <= 1'b0;
      wb_unexpected <= 1'b0;
    end else begin
      flush_q <= flush;
      if (wb_write && !busy[wb_reg] && !flush_q)
        wb_unexpected <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard. The expected values were computed by
// hand from the intended behaviour.
module tb_regfile_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic          wb_enable;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic          issue_valid;
  logic          rs1_used;
  logic          rs2_used;
  logic          issue_writes;
  logic [AW-1:0] issue_dest;
  logic          flush;
  logic          stall;
  logic          issue_accept;
  logic [AW:0]   pending_count;
`ifdef SCOREBOARD_CHECK_EN
  logic          wb_unexpected;
`endif

  int errors = 0;
  int checks = 0;

  regfile_scoreboard #(.DATA_WIDTH(DW), .NUM_REGS(32), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_enable    (wb_enable),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .issue_valid  (issue_valid),
    .rs1_used     (rs1_used),
    .rs2_used     (rs2_used),
    .issue_writes (issue_writes),
    .issue_dest   (issue_dest),
    .flush        (flush),
    .stall        (stall),
    .issue_accept (issue_accept),
    .pending_count(pending_count)
`ifdef SCOREBOARD_CHECK_EN
    ,
    .wb_unexpected(wb_unexpected)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_enable    = 1'b0;
    wb_reg       = '0;
    wb_data      = '0;
    issue_valid  = 1'b0;
    rs1_used     = 1'b0;
    rs2_used     = 1'b0;
    issue_writes = 1'b0;
    issue_dest   = '0;
    flush        = 1'b0;
  endtask

  initial begin
    idle();
    rs1_addr = '0;
    rs2_addr = '0;
    reset    = 1'b1;
    #3;
    chk("rst_pending", DW'(pending_count), 32'd0);
    chk("rst_stall", DW'(stall), 32'd0);
    chk("rst_accept", DW'(issue_accept), 32'd0);
    #9 reset = 1'b0;
    tick();

    // Reset in the middle of operation.
    wb_enable = 1'b1; wb_reg = 5'd5; wb_data = 32'h1234;
    tick();
    idle();
    issue_valid = 1'b1; issue_writes = 1'b1; issue_dest = 5'd5;
    #1 chk("r_issue_acc", DW'(issue_accept), 32'd1);
    tick();
    idle();
    rs1_addr = 5'd5;
    issue_valid = 1'b1; rs1_used = 1'b1;
    #1;
    chk("r_pend1", DW'(pending_count), 32'd1);
    chk("r_rs1_pre", rs1_data, 32'h1234);
    chk("r_stall_pre", DW'(stall), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("r_rs1_post", rs1_data, 32'd0);
    chk("r_pend_post", DW'(pending_count), 32'd0);
    chk("r_stall_post", DW'(stall), 32'd0);
`ifdef SCOREBOARD_CHECK_EN
    chk("r_unexp_clr", DW'(wb_unexpected), 32'd0);
`endif
    #2 reset = 1'b0;
    idle();
    tick();

    // Same-cycle bypass on both read ports.
    wb_enable = 1'b1; wb_reg = 5'd3; wb_data = 32'hAAAA;
    tick();
    wb_data = 32'h5555; rs1_addr = 5'd3; rs2_addr = 5'd3;
    #1;
    chk("byp_rs1", rs1_data, 32'h5555);
    chk("byp_rs2", rs2_data, 32'h5555);
    tick();
    wb_enable = 1'b0;
    #1;
    chk("byp_rs1_after", rs1_data, 32'h5555);
    chk("byp_rs2_after", rs2_data, 32'h5555);

    // RAW stall, then resolved by a write-back in the same cycle.
    idle();
    issue_valid = 1'b1; issue_writes = 1'b1; issue_dest = 5'd7;
    #1 chk("raw_acc0", DW'(issue_accept), 32'd1);
    tick();
    idle();
    chk("raw_pend1", DW'(pending_count), 32'd1);
    issue_valid = 1'b1; rs2_used = 1'b1; rs2_addr = 5'd7;
    #1;
    chk("raw_stall", DW'(stall), 32'd1);
    chk("raw_acc_blk", DW'(issue_accept), 32'd0);
    wb_enable = 1'b1; wb_reg = 5'd7; wb_data = 32'h42;
    #1;
    chk("raw_stall_res", DW'(stall), 32'd0);
    chk("raw_acc_res", DW'(issue_accept), 32'd1);
    chk("raw_rs2", rs2_data, 32'h42);
    tick();
    idle();
    chk("raw_pend0", DW'(pending_count), 32'd0);

    // WAW, and an issue and a write-back to the same register on one edge.
    issue_valid = 1'b1; issue_writes = 1'b1; issue_dest = 5'd9;
    tick();
    chk("waw_pend1", DW'(pending_count), 32'd1);
    #1 chk("waw_stall", DW'(stall), 32'd1);
    wb_enable = 1'b1; wb_reg = 5'd9; wb_data = 32'h99;
    #1;
    chk("waw_acc", DW'(issue_accept), 32'd1);
    tick();
    idle();
    chk("waw_pend_keep", DW'(pending_count), 32'd1);
    issue_valid = 1'b1; issue_writes = 1'b1; issue_dest = 5'd9;
    #1 chk("waw_busy9", DW'(stall), 32'd1);
    idle();
    wb_enable = 1'b1; wb_reg = 5'd9; wb_data = 32'h100;
    tick();
    idle();
    chk("waw_pend0", DW'(pending_count), 32'd0);

    // x0 handling.
    issue_valid = 1'b1; issue_writes = 1'b1; issue_dest = 5'd0;
    #1 chk("x0_acc", DW'(issue_accept), 32'd1);
    tick();
    idle();
    chk("x0_pend", DW'(pending_count), 32'd0);
    wb_enable = 1'b1; wb_reg = 5'd0; wb_data = 32'hFFFF; rs1_addr = 5'd0;
    #1 chk("x0_byp", rs1_data, 32'd0);
    tick();
    idle();
    chk("x0_read", rs1_data, 32'd0);

    // Flush has priority over an issue, and a write-back on the same cycle still lands.
    for (int r = 1; r <= 4; r++) begin
      issue_valid = 1'b1; issue_writes = 1'b1; issue_dest = AW'(r);
      tick();
    end
    idle();
    chk("fl_pend4", DW'(pending_count), 32'd4);
    issue_valid = 1'b1; rs1_used = 1'b1; rs1_addr = 5'd2;
    #1 chk("fl_stall_x2", DW'(stall), 32'd1);
    idle();
    issue_valid = 1'b1; issue_writes = 1'b1; issue_dest = 5'd6; flush = 1'b1;
    wb_enable = 1'b1; wb_reg = 5'd10; wb_data = 32'h77;
    #1;
    chk("fl_acc", DW'(issue_accept), 32'd0);
    chk("fl_stall", DW'(stall), 32'd0);
    tick();
    idle();
    rs2_addr = 5'd10;
    #1;
    chk("fl_pend0", DW'(pending_count), 32'd0);
    chk("fl_wb_data", rs2_data, 32'h77);
    tick();

`ifdef SCOREBOARD_CHECK_EN
    // Write-backs to non-busy registers earlier in the run already set the flag.
    wb_enable = 1'b1; wb_reg = 5'd12; wb_data = 32'h12;
    tick();
    idle();
    chk("unexp_set", DW'(wb_unexpected), 32'd1);
    tick();
    chk("unexp_sticky", DW'(wb_unexpected), 32'd1);
    reset = 1'b1;
    #1 chk("unexp_rst", DW'(wb_unexpected), 32'd0);
    reset = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
